// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus scheduler.
package lcd_pkg;

    // Transfer sequencing states; the encoding is exported on DBG_STATE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } lcd_state_e;

    // HD44780-style command codes used by the requesters.
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0c;
    localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

    // Default timing at 50 MHz (20 ns per cycle).
    localparam int unsigned DEF_SETUP_CYCLES     = 2;
    localparam int unsigned DEF_E_PULSE_CYCLES   = 12;
    localparam int unsigned DEF_HOLD_CYCLES      = 1;
    localparam int unsigned DEF_CMD_WAIT_CYCLES  = 2000;
    localparam int unsigned DEF_LONG_WAIT_CYCLES = 82000;
    localparam int unsigned DEF_CNT_W            = 17;

    // Clear (0x01) and return-home (0x02/0x03) need the long post-write wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter; the tie pointer moves only on an accepted transfer.
module lcd_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // 0: req0 wins a tie, 1: req1 wins a tie
    logic prio_q, prio_d;

    // One-hot grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // After serving a requester, the next tie goes to the other one.
    always_comb begin
        prio_d = prio_q;
        if (accept_i) begin
            prio_d = grant_o[0];
        end
    end

    // Pointer register with synchronous reset favouring req0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares the LCD pins between two byte writers and owns all E-strobe and busy-wait timing.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES     = DEF_SETUP_CYCLES,
    parameter int unsigned E_PULSE_CYCLES   = DEF_E_PULSE_CYCLES,
    parameter int unsigned HOLD_CYCLES      = DEF_HOLD_CYCLES,
    parameter int unsigned CMD_WAIT_CYCLES  = DEF_CMD_WAIT_CYCLES,
    parameter int unsigned LONG_WAIT_CYCLES = DEF_LONG_WAIT_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic       CLK_50MHZ,
    input  logic       BTN_SOUTH,
    input  logic       REQ0_VALID,
    input  logic       REQ0_RS,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic       REQ1_RS,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_READY,
    output logic [7:0] LCD_DB,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       BUSY,
    output logic       GRANT_ID,
    output logic [2:0] DBG_STATE
);

    localparam longint unsigned MAX_A = (SETUP_CYCLES > E_PULSE_CYCLES) ?
                                        SETUP_CYCLES : E_PULSE_CYCLES;
    localparam longint unsigned MAX_B = (HOLD_CYCLES > MAX_A) ? HOLD_CYCLES : MAX_A;
    localparam longint unsigned MAX_C = (CMD_WAIT_CYCLES > MAX_B) ? CMD_WAIT_CYCLES : MAX_B;
    localparam longint unsigned MAX_WAIT = (LONG_WAIT_CYCLES > MAX_C) ? LONG_WAIT_CYCLES : MAX_C;

    // Reject a counter too narrow to reach the longest phase, or a zero-length phase.
    if (CNT_W < 1 || CNT_W > 32 || MAX_WAIT >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too small for the configured waits");
    end
    if (SETUP_CYCLES < 1 || E_PULSE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        CMD_WAIT_CYCLES < 1 || LONG_WAIT_CYCLES < 1) begin : g_bad_timing
        $error("all timing parameters must be at least 1");
    end

    localparam logic [CNT_W-1:0] SETUP_C = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(E_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CMD_C   = CNT_W'(CMD_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       db_q, db_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             gid_q, gid_d;
    logic             long_q, long_d;

    logic [1:0] grant;
    logic       accept;
    logic       sel_rs;
    logic [7:0] sel_data;

    lcd_rr_arbiter u_arb (
        .clk_i    (CLK_50MHZ),
        .rst_i    (BTN_SOUTH),
        .valid_i  ({REQ1_VALID, REQ0_VALID}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // READY only offered in IDLE outside reset; the arbiter grants only valid requesters.
    always_comb begin
        REQ0_READY = (state_q == IDLE) && !BTN_SOUTH && grant[0];
        REQ1_READY = (state_q == IDLE) && !BTN_SOUTH && grant[1];
        accept     = REQ0_READY | REQ1_READY;
        sel_rs     = grant[1] ? REQ1_RS   : REQ0_RS;
        sel_data   = grant[1] ? REQ1_DATA : REQ0_DATA;
    end

    // Next-state: each timed phase starts its count at 1 and exits when it equals its length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rs_d    = rs_q;
        e_d     = e_q;
        gid_d   = gid_q;
        long_d  = long_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = ONE_C;
                    db_d    = sel_data;
                    rs_d    = sel_rs;
                    gid_d   = grant[1];
                    long_d  = is_long_cmd(sel_rs, sel_data);
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_C) begin
                    state_d = PULSE;
                    cnt_d   = ONE_C;
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_C) begin
                    state_d = HOLD;
                    cnt_d   = ONE_C;
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_C) begin
                    state_d = WAIT;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == (long_q ? LONG_C : CMD_C)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                e_d     = 1'b0;
            end
        endcase
    end

    // State, counter and pin registers; reset drops any in-flight byte.
    always_ff @(posedge CLK_50MHZ) begin
        if (BTN_SOUTH) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            db_q    <= 8'h00;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            gid_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            gid_q   <= gid_d;
            long_q  <= long_d;
        end
    end

    assign LCD_DB    = db_q;
    assign LCD_RS    = rs_q;
    assign LCD_E     = e_q;
    assign LCD_RW    = 1'b0;
    assign BUSY      = (state_q != IDLE);
    assign GRANT_ID  = gid_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: directed sequences, a vector table and a random run
// checked every cycle against a timing-window reference model.
module tb_lcd_bus_scheduler;

    // Waits shortened from the 50 MHz defaults so the long-wait path fits a short run.
    localparam int S  = 2;
    localparam int EP = 12;
    localparam int H  = 1;
    localparam int CW = 50;
    localparam int LW = 400;
    localparam int P_CMD = S + EP + H + CW + 1;

    logic       clk = 1'b0;
    logic       btn = 1'b1;
    logic       v0 = 1'b0, rs0 = 1'b0, v1 = 1'b0, rs1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       rdy0, rdy1, lcd_e, lcd_rs, lcd_rw, busy, gid;
    logic [7:0] lcd_db;
    logic [2:0] dbg;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_bus_scheduler #(
        .SETUP_CYCLES     (S),
        .E_PULSE_CYCLES   (EP),
        .HOLD_CYCLES      (H),
        .CMD_WAIT_CYCLES  (CW),
        .LONG_WAIT_CYCLES (LW),
        .CNT_W            (9)
    ) dut (
        .CLK_50MHZ  (clk),
        .BTN_SOUTH  (btn),
        .REQ0_VALID (v0),
        .REQ0_RS    (rs0),
        .REQ0_DATA  (d0),
        .REQ0_READY (rdy0),
        .REQ1_VALID (v1),
        .REQ1_RS    (rs1),
        .REQ1_DATA  (d1),
        .REQ1_READY (rdy1),
        .LCD_DB     (lcd_db),
        .LCD_E      (lcd_e),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .BUSY       (busy),
        .GRANT_ID   (gid),
        .DBG_STATE  (dbg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the last accepted byte and its accept cycle define every output
    // by time windows measured from that cycle.
    bit         m_have = 1'b0;
    int         m_t = 0;
    bit         m_long = 1'b0;
    logic [7:0] m_db = 8'h00;
    bit         m_rs = 1'b0, m_gid = 1'b0, m_tie = 1'b0;

    always @(negedge clk) begin
        int   tot;
        int   ph;
        logic r0, r1, mb;
        tot = S + EP + H + (m_long ? LW : CW);
        if (!m_have || cyc <= m_t || cyc > m_t + tot) ph = 0;
        else if (cyc <= m_t + S) ph = 1;
        else if (cyc <= m_t + S + EP) ph = 2;
        else if (cyc <= m_t + S + EP + H) ph = 3;
        else ph = 4;
        mb = (ph != 0);
        r0 = !mb && !btn && v0 && (!v1 || !m_tie);
        r1 = !mb && !btn && v1 && (!v0 || m_tie);
        if (chk_en) begin
            check("model_outputs",
                  {rdy1, rdy0, busy, lcd_e, lcd_rs, lcd_rw, gid, dbg, lcd_db},
                  {r1, r0, mb, (ph == 2), m_rs, 1'b0, m_gid, 3'(ph), m_db});
        end
        if (btn) begin
            m_have = 1'b0; m_db = 8'h00; m_rs = 1'b0; m_gid = 1'b0; m_tie = 1'b0;
        end else if (r0 || r1) begin
            m_have = 1'b1;
            m_t    = cyc;
            m_gid  = r1;
            m_db   = r1 ? d1 : d0;
            m_rs   = r1 ? rs1 : rs0;
            m_long = !m_rs && (m_db inside {8'h01, 8'h02, 8'h03});
            m_tie  = r0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
    endtask

    // Waits for READY of requester id; returns accept cycle and the other READY.
    task automatic wait_ready(input bit id, input int budget, output int t, output logic other);
        bit found = 1'b0;
        t = -1;
        other = 1'bx;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (id ? rdy1 : rdy0) begin
                found = 1'b1;
                t = cyc;
                other = id ? rdy0 : rdy1;
            end
        end
        check("ready_timeout", found, 1'b1);
        tick();
    endtask

    task automatic measure_e(output int rise, output int width);
        bit done = 1'b0;
        rise = -1;
        width = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (lcd_e) begin
                if (rise < 0) rise = cyc;
                width++;
            end else if (rise >= 0) begin
                done = 1'b1;
            end
        end
        check("e_pulse_timeout", done, 1'b1);
        tick();
    endtask

    task automatic wait_idle();
        bit found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        check("idle_timeout", found, 1'b1);
        tick();
    endtask

    typedef struct {
        bit         id;
        bit         rs;
        logic [7:0] data;
        int         exp_busy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   t, t2, t3, rise, width, prev, cnt;
        logic oth;

        tbl[0] = '{1'b0, 1'b0, 8'h38, S + EP + H + CW};
        tbl[1] = '{1'b1, 1'b0, 8'h01, S + EP + H + LW};
        tbl[2] = '{1'b1, 1'b1, 8'h01, S + EP + H + CW};
        tbl[3] = '{1'b0, 1'b0, 8'h02, S + EP + H + LW};
        tbl[4] = '{1'b0, 1'b0, 8'h03, S + EP + H + LW};
        tbl[5] = '{1'b1, 1'b0, 8'h04, S + EP + H + CW};
        tbl[6] = '{1'b0, 1'b0, 8'h00, S + EP + H + CW};
        tbl[7] = '{1'b1, 1'b0, 8'h81, S + EP + H + CW};
        tbl[8] = '{1'b0, 1'b1, 8'h02, S + EP + H + CW};

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {busy, lcd_e, lcd_rs, lcd_rw, gid, dbg, lcd_db, rdy0, rdy1},
              20'h0);
        tick();
        btn = 1'b0;

        // Single command from req0: bus setup, E window, next-accept spacing.
        v0 = 1'b1; rs0 = 1'b0; d0 = 8'h38;
        wait_ready(1'b0, 10, t, oth);
        @(negedge clk);
        check("t1_db", lcd_db, 8'h38);
        check("t1_rs_rw", {lcd_rs, lcd_rw}, 2'b00);
        check("t1_busy", busy, 1'b1);
        measure_e(rise, width);
        check("t1_e_rise", rise, t + S + 1);
        check("t1_e_width", width, EP);
        wait_ready(1'b0, 200, t2, oth);
        check("t1_next_accept", t2 - t, P_CMD);
        v0 = 1'b0;
        wait_idle();

        // Tie after reset: req0, then req1, then req0 again.
        do_reset();
        v0 = 1'b1; rs0 = 1'b0; d0 = 8'h38;
        v1 = 1'b1; rs1 = 1'b1; d1 = 8'h44;
        wait_ready(1'b0, 10, t, oth);
        check("t2_one_ready", oth, 1'b0);
        wait_ready(1'b1, 200, t2, oth);
        check("t2_req1_accept", t2 - t, P_CMD);
        @(negedge clk);
        check("t2_req1_bus", {lcd_rs, gid, lcd_db}, {1'b1, 1'b1, 8'h44});
        wait_ready(1'b0, 200, t3, oth);
        check("t2_req0_again", t3 - t2, P_CMD);
        v0 = 1'b0; v1 = 1'b0;
        wait_idle();

        // Vector table: long-wait decode and busy duration per byte.
        foreach (tbl[k]) begin
            if (tbl[k].id) begin v1 = 1'b1; rs1 = tbl[k].rs; d1 = tbl[k].data; end
            else begin v0 = 1'b1; rs0 = tbl[k].rs; d0 = tbl[k].data; end
            wait_ready(tbl[k].id, 600, t, oth);
            v0 = 1'b0; v1 = 1'b0;
            cnt = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (i == 0) check("tbl_bus", {lcd_rs, lcd_db}, {tbl[k].rs, tbl[k].data});
                if (!busy) break;
                cnt++;
            end
            check("tbl_busy_len", cnt, tbl[k].exp_busy);
            tick();
        end

        // Reset during PULSE: outputs clear next edge, pointer back to req0.
        do_reset();
        v0 = 1'b1; rs0 = 1'b0; d0 = 8'h38;
        wait_ready(1'b0, 10, t, oth);
        v0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_e) break;
        end
        check("t4_in_pulse", lcd_e, 1'b1);
        tick();
        btn = 1'b1;
        v0 = 1'b1; d0 = 8'h0c; v1 = 1'b1; rs1 = 1'b1; d1 = 8'h61;
        tick();
        @(negedge clk);
        check("t4_reset_outputs", {busy, lcd_e, lcd_rs, gid, dbg, lcd_db, rdy0, rdy1}, 18'h0);
        tick();
        btn = 1'b0;
        @(negedge clk);
        check("t4_tie_after_reset", {rdy1, rdy0}, 2'b01);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        wait_idle();

        // VALID pulsed while busy, then withdrawn: nothing written.
        do_reset();
        v1 = 1'b1; rs1 = 1'b1; d1 = 8'h55;
        wait_ready(1'b1, 10, t, oth);
        v1 = 1'b0;
        measure_e(rise, width);
        v0 = 1'b1; rs0 = 1'b1; d0 = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_ready", rdy0, 1'b0);
            tick();
        end
        v0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (lcd_e) cnt++;
        end
        check("t5_no_pulse", cnt, 0);
        check("t5_db_kept", lcd_db, 8'h55);
        tick();

        // Continuous req1 stream: pulse spacing and width.
        do_reset();
        v1 = 1'b1; rs1 = 1'b1; d1 = 8'h41;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            measure_e(rise, width);
            check("t6_width", width, EP);
            if (i > 0) check("t6_spacing", rise - prev, P_CMD);
            prev = rise;
        end
        v1 = 1'b0;
        wait_idle();

        // Random traffic, ties and resets, all checked by the model.
        for (int i = 0; i < 4000; i++) begin
            btn = ($urandom_range(0, 299) == 0);
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            rs0 = $urandom_range(0, 1);
            rs1 = $urandom_range(0, 1);
            d0  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            d1  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            tick();
        end
        btn = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
